// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants, the queue entry type, the requester enum and
// the free-slot helper used by the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int RF_WB_DEPTH  = 4;
    localparam int RF_WB_CNT_W  = 3;
    localparam int RF_WB_RD_W   = 5;
    localparam int RF_WB_DATA_W = 32;

    typedef struct packed {
        logic [RF_WB_RD_W-1:0]   rd;
        logic [RF_WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_ALU = 1'b1
    } wb_req_e;

    // The head pops every cycle it is valid, so its slot is reusable the same cycle.
    function automatic logic [RF_WB_CNT_W-1:0] free_slots(input logic [RF_WB_CNT_W-1:0] cnt);
        return RF_WB_CNT_W'(RF_WB_DEPTH) - cnt + {2'b00, (cnt != '0)};
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: 4-entry in-order write queue, up to two pushes and one pop per
// cycle, with per-entry destination compares against two source registers.
// Storage is not reset; only pointers and count are.
module rf_wb_fifo
    import rf_wb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  wb_entry_t              push0_ent,
    input  logic                   push1,
    input  wb_entry_t              push1_ent,
    input  logic                   pop,
    input  logic [RF_WB_RD_W-1:0]  ra,
    input  logic [RF_WB_RD_W-1:0]  rb,
    output wb_entry_t              head,
    output logic [RF_WB_CNT_W-1:0] count,
    output logic [RF_WB_DEPTH-1:0] hit_a,
    output logic [RF_WB_DEPTH-1:0] hit_b
);

    wb_entry_t                slots [RF_WB_DEPTH];
    logic [1:0]               rd_ptr;
    logic [1:0]               wr_ptr;
    logic                     pop_ok;
    logic [RF_WB_DEPTH-1:0]   valid;

    assign pop_ok = pop && (count != '0);
    assign head   = slots[rd_ptr];

    // Control state: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + 2'(pop_ok);
            wr_ptr <= wr_ptr + 2'(push0) + 2'(push1);
            count  <= count + RF_WB_CNT_W'(push0) + RF_WB_CNT_W'(push1) - RF_WB_CNT_W'(pop_ok);
        end
    end

    // Entry storage: push0 lands first, push1 directly behind it.
    always_ff @(posedge clk) begin
        if (push0) slots[wr_ptr] <= push0_ent;
        if (push1) slots[wr_ptr + 2'd1] <= push1_ent;
    end

    // Occupancy per slot and destination-register matches for hazard detection.
    always_comb begin
        valid = '0;
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < RF_WB_DEPTH; i++) begin
            valid[i] = ({1'b0, 2'(i) - rd_ptr} < count);
            hit_a[i] = valid[i] && (slots[i].rd == ra);
            hit_b[i] = valid[i] && (slots[i].rd == rb);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates load and ALU writebacks into a 4-entry queue that
// retires one register-file write per cycle, and flags decode-stage hazards.
// Optional macro RF_WB_RR_EN: alternate mem/alu priority on contention cycles;
// undefined, mem always wins and no priority state exists.
module rf_wb_arbiter
    import rf_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic [RF_WB_RD_W-1:0]   mem_rd,
    input  logic [RF_WB_DATA_W-1:0] mem_data,
    output logic                    mem_gnt,
    input  logic                    alu_req,
    input  logic [RF_WB_RD_W-1:0]   alu_rd,
    input  logic [RF_WB_DATA_W-1:0] alu_data,
    output logic                    alu_gnt,
    output logic                    rf_write,
    output logic [RF_WB_RD_W-1:0]   rf_rd,
    output logic [RF_WB_DATA_W-1:0] rf_data,
    input  logic [RF_WB_RD_W-1:0]   ra,
    input  logic [RF_WB_RD_W-1:0]   rb,
    output logic                    hazard_a,
    output logic                    hazard_b,
    output logic [RF_WB_CNT_W-1:0]  count
);

    wb_entry_t                mem_ent;
    wb_entry_t                alu_ent;
    wb_entry_t                push0_ent;
    wb_entry_t                push1_ent;
    wb_entry_t                head;
    logic                     push0;
    logic                     push1;
    logic                     mem_nz;
    logic                     alu_nz;
    logic                     both_nz;
    logic                     mem_win;
    logic                     alu_win;
    logic                     mem_first;
    logic [RF_WB_CNT_W-1:0]   free;
    logic [RF_WB_DEPTH-1:0]   hit_a;
    logic [RF_WB_DEPTH-1:0]   hit_b;

    assign mem_ent = {mem_rd, mem_data};
    assign alu_ent = {alu_rd, alu_data};
    assign mem_nz  = mem_req && (mem_rd != '0);
    assign alu_nz  = alu_req && (alu_rd != '0);
    assign both_nz = mem_nz && alu_nz;
    assign free    = free_slots(count);

`ifdef RF_WB_RR_EN
    wb_req_e prio;

    // Priority pointer flips once a contention winner has been chosen.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_MEM;
        end else if (both_nz && (free != '0)) begin
            prio <= (prio == REQ_MEM) ? REQ_ALU : REQ_MEM;
        end
    end

    assign mem_first = (prio == REQ_MEM);
`else
    assign mem_first = 1'b1;
`endif

    // Grants and queue pushes; rd=0 requests are acknowledged without a slot.
    always_comb begin
        mem_win   = 1'b0;
        alu_win   = 1'b0;
        mem_gnt   = 1'b0;
        alu_gnt   = 1'b0;
        push0     = 1'b0;
        push1     = 1'b0;
        push0_ent = mem_ent;
        push1_ent = alu_ent;
        if (!rst) begin
            if (free >= 3'd2) begin
                mem_win = mem_nz;
                alu_win = alu_nz;
            end else if (free == 3'd1) begin
                if (both_nz) begin
                    mem_win = mem_first;
                    alu_win = !mem_first;
                end else begin
                    mem_win = mem_nz;
                    alu_win = alu_nz;
                end
            end
            mem_gnt = mem_win || (mem_req && (mem_rd == '0));
            alu_gnt = alu_win || (alu_req && (alu_rd == '0));
            if (mem_win && alu_win) begin
                push0 = 1'b1;
                push1 = 1'b1;
                if (!mem_first) begin
                    push0_ent = alu_ent;
                    push1_ent = mem_ent;
                end
            end else if (mem_win) begin
                push0 = 1'b1;
            end else if (alu_win) begin
                push0     = 1'b1;
                push0_ent = alu_ent;
            end
        end
    end

    rf_wb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0     (push0),
        .push0_ent (push0_ent),
        .push1     (push1),
        .push1_ent (push1_ent),
        .pop       (count != '0),
        .ra        (ra),
        .rb        (rb),
        .head      (head),
        .count     (count),
        .hit_a     (hit_a),
        .hit_b     (hit_b)
    );

    // Register-bank write port driven straight from the queue head.
    always_comb begin
        rf_write = 1'b0;
        rf_rd    = '0;
        rf_data  = '0;
        if (!rst && (count != '0)) begin
            rf_write = 1'b1;
            rf_rd    = head.rd;
            rf_data  = head.data;
        end
    end

    assign hazard_a = !rst && (ra != '0) && (|hit_a);
    assign hazard_b = !rst && (rb != '0) && (|hit_b);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios for rf_wb_arbiter. Inputs change just
// after the falling edge; outputs are sampled 1ns later, away from posedge.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_gnt;
    logic        alu_req = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_gnt;
    logic        rf_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;
    logic        hazard_a;
    logic        hazard_b;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_gnt  (mem_gnt),
        .alu_req  (alu_req),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .alu_gnt  (alu_gnt),
        .rf_write (rf_write),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data),
        .ra       (ra),
        .rb       (rb),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task test_reset;
        repeat (2) @(negedge clk);
        mem_req = 1'b1; mem_rd = 5'd9; mem_data = 32'h1; ra = 5'd9;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("FAIL reset_rf_write: got %b expected 0", rf_write); end
        n_checks++; if (mem_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_mem_gnt: got %b expected 0", mem_gnt); end
        n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL reset_hazard_a: got %b expected 0", hazard_a); end
        mem_req = 1'b0; ra = 5'd0; rst = 1'b0;
    endtask

    task test_single;
        @(negedge clk);
        mem_req = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA0001;
        #1;
        n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b expected 1", mem_gnt); end
        n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("FAIL single_pre_write: got %b expected 0", rf_write); end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        n_checks++; if (rf_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %b expected 1", rf_write); end
        n_checks++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL single_rd: got %0d expected 5", rf_rd); end
        n_checks++; if (rf_data !== 32'hAAAA0001) begin n_fail++; $display("FAIL single_data: got %h expected aaaa0001", rf_data); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count); end
        @(negedge clk); #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", count); end
        n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("FAIL single_idle_write: got %b expected 0", rf_write); end
    endtask

    task test_dual;
        @(negedge clk);
        mem_req = 1'b1; mem_rd = 5'd3; mem_data = 32'h33330003;
        alu_req = 1'b1; alu_rd = 5'd4; alu_data = 32'h44440004;
        #1;
        n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL dual_mem_gnt: got %b expected 1", mem_gnt); end
        n_checks++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL dual_alu_gnt: got %b expected 1", alu_gnt); end
        @(negedge clk);
        mem_req = 1'b0; alu_req = 1'b0;
        #1;
        n_checks++; if (rf_rd !== 5'd3) begin n_fail++; $display("FAIL dual_first_rd: got %0d expected 3", rf_rd); end
        n_checks++; if (rf_data !== 32'h33330003) begin n_fail++; $display("FAIL dual_first_data: got %h expected 33330003", rf_data); end
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL dual_count2: got %0d expected 2", count); end
        @(negedge clk); #1;
        n_checks++; if (rf_rd !== 5'd4) begin n_fail++; $display("FAIL dual_second_rd: got %0d expected 4", rf_rd); end
        n_checks++; if (rf_data !== 32'h44440004) begin n_fail++; $display("FAIL dual_second_data: got %h expected 44440004", rf_data); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL dual_count1: got %0d expected 1", count); end
        @(negedge clk); #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL dual_count0: got %0d expected 0", count); end
    endtask

    // Fills the queue to 4, then holds both requesters against a full queue.
    task test_contention;
        logic prev_mem;
        prev_mem = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_req = 1'b1; mem_rd = 5'(1 + 2 * k); mem_data = 32'(100 + k);
            alu_req = 1'b1; alu_rd = 5'(2 + 2 * k); alu_data = 32'(200 + k);
            #1;
            n_checks++; if ({mem_gnt, alu_gnt} !== 2'b11) begin n_fail++; $display("FAIL fill_gnt[%0d]: got %b expected 11", k, {mem_gnt, alu_gnt}); end
        end
        @(negedge clk);
        mem_rd = 5'd8; mem_data = 32'h8;
        alu_rd = 5'd9; alu_data = 32'h9;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL cont_count[%0d]: got %0d expected 4", k, count); end
            n_checks++; if ((mem_gnt ^ alu_gnt) !== 1'b1) begin n_fail++; $display("FAIL cont_one_gnt[%0d]: got mem=%b alu=%b expected exactly one", k, mem_gnt, alu_gnt); end
`ifdef RF_WB_RR_EN
            if (k > 0) begin
                n_checks++; if (mem_gnt === prev_mem) begin n_fail++; $display("FAIL cont_alternate[%0d]: got mem_gnt=%b expected %b", k, mem_gnt, !prev_mem); end
            end
`else
            n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL cont_mem_wins[%0d]: got %b expected 1", k, mem_gnt); end
`endif
            prev_mem = mem_gnt;
            @(negedge clk);
        end
    endtask

    // Queue is full on entry; an rd=0 request must not take a slot.
    task test_rd_zero;
        mem_req = 1'b1; mem_rd = 5'd11; mem_data = 32'hB;
        alu_req = 1'b1; alu_rd = 5'd0;  alu_data = 32'hDEAD;
        #1;
        n_checks++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL zero_alu_gnt: got %b expected 1", alu_gnt); end
        n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL zero_mem_gnt: got %b expected 1", mem_gnt); end
        @(negedge clk);
        mem_req = 1'b0; alu_req = 1'b0;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL zero_count: got %0d expected 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rf_write !== 1'b1) begin n_fail++; $display("FAIL drain_write[%0d]: got %b expected 1", i, rf_write); end
            n_checks++; if (rf_rd === 5'd0) begin n_fail++; $display("FAIL drain_rd_nonzero[%0d]: got 0 expected nonzero", i); end
            if (i == 3) begin
                n_checks++; if (rf_rd !== 5'd11) begin n_fail++; $display("FAIL drain_last_rd: got %0d expected 11", rf_rd); end
            end
            @(negedge clk); #1;
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
        n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %b expected 0", rf_write); end
    endtask

    task test_hazard;
        @(negedge clk);
        mem_req = 1'b1; mem_rd = 5'd2; mem_data = 32'h21;
        alu_req = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        ra = 5'd7; rb = 5'd0;
        #1;
        n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL haz_empty: got %b expected 0", hazard_a); end
        @(negedge clk);
        alu_req = 1'b0; mem_rd = 5'd7; mem_data = 32'h77;
        #1;
        n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL haz_push_gnt: got %b expected 1", mem_gnt); end
        n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL haz_not_queued: got %b expected 0", hazard_a); end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL haz_count: got %0d expected 2", count); end
        n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL haz_a_tail: got %b expected 1", hazard_a); end
        n_checks++; if (hazard_b !== 1'b0) begin n_fail++; $display("FAIL haz_b_zero: got %b expected 0", hazard_b); end
        rb = 5'd2;
        #1;
        n_checks++; if (hazard_b !== 1'b1) begin n_fail++; $display("FAIL haz_b_head: got %b expected 1", hazard_b); end
        rb = 5'd0;
        @(negedge clk); #1;
        n_checks++; if (rf_rd !== 5'd7) begin n_fail++; $display("FAIL haz_head_rd: got %0d expected 7", rf_rd); end
        n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL haz_a_head: got %b expected 1", hazard_a); end
        @(negedge clk); #1;
        n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL haz_a_cleared: got %b expected 0", hazard_a); end
        ra = 5'd0;
    endtask

    task test_reset_inflight;
        @(negedge clk);
        mem_req = 1'b1; mem_rd = 5'd1; alu_req = 1'b1; alu_rd = 5'd2;
        @(negedge clk);
        mem_rd = 5'd3; alu_rd = 5'd4;
        @(negedge clk);
        mem_req = 1'b0; alu_req = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 3", count); end
        rst = 1'b1; ra = 5'd3;
        mem_req = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0C0000C;
        alu_req = 1'b1; alu_rd = 5'd13; alu_data = 32'hD0D0000D;
        #1;
        n_checks++; if ({mem_gnt, alu_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", {mem_gnt, alu_gnt}); end
        n_checks++; if (rf_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b expected 0", rf_write); end
        n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %b expected 0", hazard_a); end
        @(negedge clk); #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_checks++; if (mem_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_hold_gnt: got %b expected 0", mem_gnt); end
        rst = 1'b0; ra = 5'd0;
        #1;
        n_checks++; if ({mem_gnt, alu_gnt} !== 2'b11) begin n_fail++; $display("FAIL rel_gnt: got %b expected 11", {mem_gnt, alu_gnt}); end
        @(negedge clk);
        mem_req = 1'b0; alu_req = 1'b0;
        #1;
        n_checks++; if (rf_rd !== 5'd12) begin n_fail++; $display("FAIL rel_first_rd: got %0d expected 12", rf_rd); end
        n_checks++; if (rf_data !== 32'hC0C0000C) begin n_fail++; $display("FAIL rel_first_data: got %h expected c0c0000c", rf_data); end
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rel_count: got %0d expected 2", count); end
        @(negedge clk); #1;
        n_checks++; if (rf_rd !== 5'd13) begin n_fail++; $display("FAIL rel_second_rd: got %0d expected 13", rf_rd); end
        @(negedge clk); #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rel_drain: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_contention();
        test_rd_zero();
        test_hazard();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 mem_req  in  1  load-writeback request; mem_rd, mem_data held stable until granted.
REQ-004 mem_rd  in  5  load destination register.
REQ-005 mem_data  in  32  load writeback data.
REQ-006 mem_gnt  out  1  load write accepted at this posedge (combinational).
REQ-007 alu_req, alu_rd, alu_data, alu_gnt  in/in/in/out  1/5/32/1  ALU-writeback channel; same rules as mem_*.
REQ-008 rf_write  out  1  register-bank write enable.
REQ-009 rf_rd  out  5  register-bank destination.
REQ-010 rf_data  out  32  register-bank write data.
REQ-011 ra, rb  in  5  decode-stage source register numbers.
REQ-012 hazard_a, hazard_b  out  1  pending queued write to ra / rb.
REQ-013 count  out  3  number of valid queue entries, 0..4.

Function
REQ-014 The block SHALL hold a 4-entry in-order write queue; each entry carries {rd, data}.
REQ-015 The head entry SHALL drive rf_write=1, rf_rd, rf_data combinationally whenever count>0, and SHALL pop at every posedge while count>0 (one write per cycle).
REQ-016 When count=0: rf_write=0, rf_rd=0, rf_data=0.
REQ-017 free = 4 - count + (count>0 ? 1 : 0); this SHALL be the number of pushes allowed this cycle.
REQ-018 Requests with rd=0 SHALL be granted immediately, never enqueued, and SHALL consume no slot.
REQ-019 free>=2: all nonzero-rd requests SHALL be granted in the same cycle.
REQ-020 free=1 with two nonzero-rd requests: exactly one SHALL be granted per priority (REQ-030).
REQ-021 free=0: no nonzero-rd request SHALL be granted.
REQ-022 Two grants in one cycle SHALL enqueue the priority winner first, then the other entry.
REQ-023 Push and pop in the same cycle: count_next = count + pushes - pop, never exceeding 4.
REQ-024 Write-to-visibility latency: an entry granted into an empty queue SHALL appear on rf_* the next cycle.
REQ-025 hazard_a SHALL be 1 iff ra!=0 and any valid entry (head included) has rd=ra; hazard_b likewise for rb; both purely combinational.
REQ-026 Same-rd entries SHALL be retired strictly in queue order, so the youngest value lands last.

Reset
REQ-027 rst=1 at posedge SHALL empty the queue (count=0), set the priority pointer to mem, and discard any in-flight entries.
REQ-028 While rst=1: mem_gnt=alu_gnt=0, rf_write=0, and hazard_a=hazard_b=0.
REQ-029 Requests pending across reset SHALL remain held by requesters and SHALL be arbitrated normally from the first cycle with rst=0.

Configuration
REQ-030 Macro RF_WB_RR_EN defined: on a contention cycle (REQ-020/022), priority SHALL alternate between mem and alu; the pointer updates only on contention cycles, after the first winner is decided.
REQ-031 RF_WB_RR_EN undefined: mem SHALL always win contention; no pointer state SHALL exist.

Structure
REQ-032 Package rf_wb_pkg SHALL hold RF_WB_DEPTH=4, the entry struct typedef {rd[4:0], data[31:0]}, and the requester enum {REQ_MEM, REQ_ALU}.
REQ-033 Sub-module rf_wb_fifo SHALL implement the 2-push/1-pop queue with count and per-entry rd compare outputs; arbitration and grant logic SHALL stay in rf_wb_arbiter.

Verification
REQ-034 Empty queue, mem_req rd=5 data=0xAAAA0001 -> mem_gnt=1 same cycle; next cycle rf_write=1, rf_rd=5, rf_data=0xAAAA0001; then count=0.
REQ-035 Empty queue, both requests, mem rd=3, alu rd=4 -> both granted; rf_rd=3 then rf_rd=4 on consecutive cycles.
REQ-036 count=4, both requesting -> free=1. Without RF_WB_RR_EN, mem granted every contention cycle. With the macro, winners alternate mem, alu, mem.
REQ-037 alu_req rd=0 with queue full -> alu_gnt=1, count unchanged, no rf_write for it.
REQ-038 Queue holds rd=7; ra=7, rb=0 -> hazard_a=1, hazard_b=0; hazard_a falls to 0 the cycle after the rd=7 entry pops.
REQ-039 rst asserted with count=3 -> next cycle count=0, rf_write=0, grants 0 while rst=1; held requests granted the first cycle after release.
